// File: rtl/cond_pkg.sv
// -----------------------------------------------------------------------------
// cond_pkg
//
// Shared definitions for the condition-select path of the microprogrammed
// machine. The sequencer, the microcode assembler and the flag register all
// agree on where each condition lives on the condition bus through the index
// constants below.
//
// Contents:
//   COND_TRUE      - bit index of the constant-1 (unconditional) condition
//   COND_Z/N/C/V   - bit indices of the registered ALU status flags
//   COND_EVT_BASE  - bit index of the first sticky external event flag
//   alu_flags_t    - packed bundle of the four ALU status flags
//   evt_index()    - condition-bus index of event flag i
// -----------------------------------------------------------------------------
package cond_pkg;

    localparam int COND_TRUE     = 0;
    localparam int COND_Z        = 1;
    localparam int COND_N        = 2;
    localparam int COND_C        = 3;
    localparam int COND_V        = 4;
    localparam int COND_EVT_BASE = 5;

    // The four ALU flags always load together, so they travel as one word.
    typedef struct packed {
        logic v;
        logic c;
        logic n;
        logic z;
    } alu_flags_t;

    // Position of external event i on the condition bus.
    function automatic int evt_index(input int i);
        return COND_EVT_BASE + i;
    endfunction

endpackage : cond_pkg

// File: rtl/sync_edge_detect.sv
// -----------------------------------------------------------------------------
// sync_edge_detect
//
// Brings one asynchronous level input into the clk domain through a chain of
// SYNC_STAGES flip-flops and produces a single-cycle pulse on each low-to-high
// transition of the synchronized level.
//
// Ports:
//   clk       in   system clock
//   rst       in   asynchronous active-high reset; clears the chain and prev
//   async_in  in   asynchronous level input
//   rise      out  one-cycle pulse when the synchronized level goes 0 -> 1
//
// Because prev resets to 0, a level that is already high when reset releases
// is reported as one rise once it has crossed the synchronizer.
// -----------------------------------------------------------------------------
module sync_edge_detect #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic async_in,
    output logic rise
);

    logic [SYNC_STAGES-1:0] sync_chain;
    logic                   sync_level;
    logic                   prev;

    // Stage 0 samples the raw input; the last stage is the synchronized level.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_chain <= '0;
        end else begin
            sync_chain <= {sync_chain[SYNC_STAGES-2:0], async_in};
        end
    end

    assign sync_level = sync_chain[SYNC_STAGES-1];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            prev <= 1'b0;
        end else begin
            prev <= sync_level;
        end
    end

    assign rise = sync_level & ~prev;

endmodule : sync_edge_detect

// File: rtl/cond_flag_register.sv
// -----------------------------------------------------------------------------
// cond_flag_register
//
// Producer side of the condition-select path. Registers the ALU status flags,
// turns asynchronous external events into sticky synchronized flags, and
// presents everything as one condition bus indexed by the sequencer's
// condition multiplexer.
//
// Condition bus layout:
//   bit 0                       constant 1 (unconditional branch)
//   bits 1..4                   Z, N, C, V
//   bits 5..5+EXT_BITS-1        sticky event flags EVT[i]
//   remaining bits              constant 0
//
// Ports:
//   clk        in   system clock
//   rst        in   asynchronous active-high reset
//   alu_z      in   ALU zero flag
//   alu_n      in   ALU negative flag
//   alu_c      in   ALU carry flag
//   alu_v      in   ALU overflow flag
//   flags_we   in   load all four ALU flags at this edge
//   ext_in     in   asynchronous event inputs (levels)
//   ack_valid  in   sequencer consumed the condition selected by ack_sel
//   ack_sel    in   index of the consumed condition bit
//   cond_bits  out  condition bus (registers and constants only)
//
// Parameters must satisfy 5 + EXT_BITS <= 2**SEL_BITS and SYNC_STAGES >= 2.
// -----------------------------------------------------------------------------
module cond_flag_register
    import cond_pkg::*;
#(
    parameter int SEL_BITS    = 3,
    parameter int EXT_BITS    = 2,
    parameter int SYNC_STAGES = 2
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   alu_z,
    input  logic                   alu_n,
    input  logic                   alu_c,
    input  logic                   alu_v,
    input  logic                   flags_we,
    input  logic [EXT_BITS-1:0]    ext_in,
    input  logic                   ack_valid,
    input  logic [SEL_BITS-1:0]    ack_sel,
    output logic [2**SEL_BITS-1:0] cond_bits
);

    localparam int COND_W = 2**SEL_BITS;

    alu_flags_t          flags;
    alu_flags_t          flags_in;
    logic [EXT_BITS-1:0] evt;
    logic [EXT_BITS-1:0] evt_next;
    logic [EXT_BITS-1:0] evt_rise;
    logic [EXT_BITS-1:0] evt_clr;

    // -------------------------------------------------------------------------
    // ALU flag register: all four flags load together or not at all.
    // -------------------------------------------------------------------------
    assign flags_in = '{v: alu_v, c: alu_c, n: alu_n, z: alu_z};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            flags <= '0;
        end else if (flags_we) begin
            flags <= flags_in;
        end
    end

    // -------------------------------------------------------------------------
    // One synchronizer plus rise detector per external event input.
    // -------------------------------------------------------------------------
    for (genvar gi = 0; gi < EXT_BITS; gi++) begin : g_evt_sync
        sync_edge_detect #(
            .SYNC_STAGES (SYNC_STAGES)
        ) u_sync (
            .clk      (clk),
            .rst      (rst),
            .async_in (ext_in[gi]),
            .rise     (evt_rise[gi])
        );
    end

    // -------------------------------------------------------------------------
    // Sticky event flags. An acknowledge only clears the event it addresses;
    // acknowledges of the ALU flags, the constant bits or unused bits match
    // no event and fall through harmlessly.
    // -------------------------------------------------------------------------
    always_comb begin
        evt_clr = '0;
        for (int i = 0; i < EXT_BITS; i++) begin
            evt_clr[i] = ack_valid && (int'(ack_sel) == evt_index(i));
        end
    end

    // A rise arriving in the same cycle as the acknowledge of that event must
    // not be lost, so the set term is OR-ed in after the clear.
    assign evt_next = evt_rise | (evt & ~evt_clr);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            evt <= '0;
        end else begin
            evt <= evt_next;
        end
    end

    // -------------------------------------------------------------------------
    // Condition bus: pure wiring of registers and constants.
    // -------------------------------------------------------------------------
    always_comb begin
        cond_bits            = '0;
        cond_bits[COND_TRUE] = 1'b1;
        cond_bits[COND_Z]    = flags.z;
        cond_bits[COND_N]    = flags.n;
        cond_bits[COND_C]    = flags.c;
        cond_bits[COND_V]    = flags.v;
        for (int i = 0; i < EXT_BITS; i++) begin
            if (evt_index(i) < COND_W) begin
                cond_bits[evt_index(i)] = evt[i];
            end
        end
    end

endmodule : cond_flag_register
